cacheline_adaptor: RTL



---
 rtl/cacheline_adaptor.sv | 118 +++++++++++
 1 files changed

// File: rtl/cacheline_adaptor.sv
// Cacheline adaptor: turns one LINE_W-bit fill or write-back from the data cache
// into a sequence of BURST_W-bit beats on the main-memory burst bus.
module cacheline_adaptor #(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // cache side
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  // memory side
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int unsigned BEATS = LINE_W / BURST_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFF_W = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LINE_W-1:0]  wline_q;
  logic [LINE_W-1:0]  rline_q;
  logic               read_q;
  logic               write_q;
  logic               resp_q;

  assign line_o    = rline_q;
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;

  // Write beat follows the counter directly so it advances on the ack edge.
  assign burst_o = write_q ? wline_q[32'(cnt_q) * BURST_W +: BURST_W] : '0;

  // Transfer FSM; request inputs are only sampled in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (read_i) begin
            addr_q  <= address_i & ADDR_MASK;
            cnt_q   <= '0;
            read_q  <= 1'b1;
            state_q <= READ;
          end else if (write_i) begin
            addr_q  <= address_i & ADDR_MASK;
            wline_q <= line_i;
            cnt_q   <= '0;
            write_q <= 1'b1;
            state_q <= WRITE;
          end
        end
        READ: begin
          if (resp_i) begin
            rline_q[32'(cnt_q) * BURST_W +: BURST_W] <= burst_i;
            if (cnt_q == LAST_BEAT) begin
              read_q  <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            if (cnt_q == LAST_BEAT) begin
              write_q <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
